// File: rtl/tt_scan_driver.sv
// tt_scan_driver: runs one full TT03-style scan chain access (shift in, latch,
// capture, shift out) and derives every scan-chain signal from clk12MHz.
module tt_scan_driver #(
  parameter int CLK_DIV = 6,
  parameter int CNT_W   = 8
) (
  input  logic       clk12MHz,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] data_out,
  output logic       sc_clk,
  output logic       sc_data,
  output logic       sc_latch_en,
  output logic       sc_select,
  input  logic       sc_return
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SHIFT_IN  = 3'd1,
    S_LATCH     = 3'd2,
    S_CAPTURE   = 3'd3,
    S_SHIFT_OUT = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] div_reg, div_next;
  logic             phase_reg, phase_next;
  logic [2:0]       bit_reg, bit_next;
  logic [7:0]       shift_reg, shift_next;
  logic [7:0]       rx_reg, rx_next;
  logic [7:0]       data_out_reg, data_out_next;

  logic busy_reg, busy_next;
  logic done_reg, done_next;
  logic sc_clk_reg, sc_clk_next;
  logic sc_data_reg, sc_data_next;
  logic sc_latch_en_reg, sc_latch_en_next;
  logic sc_select_reg, sc_select_next;

  logic half_end;
  logic slot_end;
  logic clocked_next;

  // A slot is a low half (phase 0) followed by a high half (phase 1),
  // each CLK_DIV cycles long.
  assign half_end = (div_reg == DIV_LAST);
  assign slot_end = half_end && phase_reg;

  always_comb begin
    state_next    = state_reg;
    div_next      = div_reg;
    phase_next    = phase_reg;
    bit_next      = bit_reg;
    shift_next    = shift_reg;
    rx_next       = rx_reg;
    data_out_next = data_out_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_SHIFT_IN;
          shift_next = data_in;
          bit_next   = 3'd0;
          div_next   = '0;
          phase_next = 1'b0;
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        if (half_end) begin
          div_next   = '0;
          phase_next = ~phase_reg;
        end else begin
          div_next = div_reg + CNT_W'(1);
        end

        case (state_reg)
          S_SHIFT_IN: begin
            if (slot_end) begin
              shift_next = {shift_reg[6:0], 1'b0};
              if (bit_reg == 3'd7) begin
                state_next = S_LATCH;
                bit_next   = 3'd0;
              end else begin
                bit_next = bit_reg + 3'd1;
              end
            end
          end

          S_LATCH: begin
            if (slot_end) state_next = S_CAPTURE;
          end

          S_CAPTURE: begin
            if (slot_end) begin
              state_next = S_SHIFT_OUT;
              bit_next   = 3'd0;
            end
          end

          S_SHIFT_OUT: begin
            // Sample on the edge that raises sc_clk, so we see the chain's
            // output before it shifts.
            if (half_end && !phase_reg) rx_next = {rx_reg[6:0], sc_return};
            if (slot_end) begin
              if (bit_reg == 3'd7) begin
                state_next    = S_DONE;
                data_out_next = rx_reg;
                bit_next      = 3'd0;
              end else begin
                bit_next = bit_reg + 3'd1;
              end
            end
          end

          default: ;
        endcase
      end
    endcase

    // Outputs are registered from the next-state view so they line up with
    // the state they belong to and come straight from flops.
    clocked_next = (state_next == S_SHIFT_IN) || (state_next == S_CAPTURE) ||
                   (state_next == S_SHIFT_OUT);
    busy_next        = (state_next != S_IDLE) && (state_next != S_DONE);
    done_next        = (state_next == S_DONE);
    sc_clk_next      = clocked_next && phase_next;
    sc_data_next     = (state_next == S_SHIFT_IN) ? shift_next[7] : 1'b0;
    sc_latch_en_next = (state_next == S_LATCH);
    sc_select_next   = (state_next == S_CAPTURE);
  end

  always_ff @(posedge clk12MHz) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      div_reg         <= '0;
      phase_reg       <= 1'b0;
      bit_reg         <= 3'd0;
      shift_reg       <= 8'd0;
      rx_reg          <= 8'd0;
      data_out_reg    <= 8'd0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      sc_clk_reg      <= 1'b0;
      sc_data_reg     <= 1'b0;
      sc_latch_en_reg <= 1'b0;
      sc_select_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      div_reg         <= div_next;
      phase_reg       <= phase_next;
      bit_reg         <= bit_next;
      shift_reg       <= shift_next;
      rx_reg          <= rx_next;
      data_out_reg    <= data_out_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
      sc_clk_reg      <= sc_clk_next;
      sc_data_reg     <= sc_data_next;
      sc_latch_en_reg <= sc_latch_en_next;
      sc_select_reg   <= sc_select_next;
    end
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign data_out    = data_out_reg;
  assign sc_clk      = sc_clk_reg;
  assign sc_data     = sc_data_reg;
  assign sc_latch_en = sc_latch_en_reg;
  assign sc_select   = sc_select_reg;

endmodule
